lsu: RTL

Load/store unit for the tinywhisper RISC-V core. It takes the effective address computed by the ALU for `OP_LW`/`OP_SW` instructions, together with `funct3` and the store data (rs2). It runs one or two word-wide transactions on the data-memory bus using a req/ready handshake, applies byte lanes and sign/zero extension, and returns load data for register writeback. It sits between the execute stage and the data-memory port, and stalls the core through `busy` until `done`.

---
 rtl/lsu.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one or two word-wide bus transactions per LW/SW-class op,
// with byte-lane steering and load extension. Split word-crossing accesses are enabled by `LSU_MISALIGNED_EN.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       rdata_q, rdata_d;

  logic in_illegal, in_misal;
  assign in_illegal = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]) ||
                      (is_store && funct3[2]);
`ifdef LSU_MISALIGNED_EN
  assign in_misal = 1'b0;
`else
  assign in_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif

  logic [1:0]        off;
  logic [3:0]        mask;
  logic [7:0]        be8;
  logic [63:0]       wd64, ld64;
  logic [31:0]       ld_raw, ld_ext;
  logic [ADDR_W-1:0] word0, word1;

  assign off = addr_q[1:0];

  always_comb begin
    mask = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // Upper nibble / upper word hold the lanes that spill into the next word.
  assign be8   = {4'b0000, mask} << off;
  assign wd64  = {32'h0, wdata_q} << {off, 3'b000};
  assign word0 = {addr_q[ADDR_W-1:2], 2'b00};
  assign word1 = word0 + ADDR_W'(4);

  assign ld64   = (state_q == S_ACC1) ? {mem_rdata, rbuf_q} : {32'h0, mem_rdata};
  assign ld_raw = 32'(ld64 >> {off, 3'b000});

  always_comb begin
    ld_ext = ld_raw;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
      3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          fault_d    = in_illegal || in_misal;
          state_d    = (in_illegal || in_misal) ? S_FIN : S_ACC0;
        end
      end
      S_ACC0: begin
        if (mem_ready) begin
          rbuf_d = mem_rdata;
`ifdef LSU_MISALIGNED_EN
          if (|be8[7:4]) begin
            state_d = S_ACC1;
          end else begin
            state_d = S_FIN;
            if (!is_store_q) rdata_d = ld_ext;
          end
`else
          state_d = S_FIN;
          if (!is_store_q) rdata_d = ld_ext;
`endif
        end
      end
      S_ACC1: begin
        if (mem_ready) begin
          state_d = S_FIN;
          if (!is_store_q) rdata_d = ld_ext;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      fault_q    <= 1'b0;
      rbuf_q     <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
    end
  end

  // Bus outputs are decoded from state and held request fields, so they stay
  // stable across wait states and drop straight away on async reset.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign fault     = (state_q == S_FIN) && fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == S_ACC0) || (state_q == S_ACC1);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = (state_q == S_ACC0) ? word0 : (state_q == S_ACC1) ? word1 : '0;
  assign mem_be    = (state_q == S_ACC0) ? be8[3:0] : (state_q == S_ACC1) ? be8[7:4] : 4'h0;
  assign mem_wdata = (state_q == S_ACC0) ? wd64[31:0] : (state_q == S_ACC1) ? wd64[63:32] : 32'h0;

endmodule
